// File: rtl/mas_mul_bist_if.sv
// ============================================================================
// mas_mul_bist_if : control, status and multiplier-facing bus of mas_mul_bist
// Rev 1.0 -- optional inj_err under MAS_MUL_BIST_ERR_INJECT_EN
// ============================================================================
`default_nettype none

interface mas_mul_bist_if #(
  parameter int unsigned WIDTH = 16
);
  logic                 start;
  logic [WIDTH-1:0]     mul_in1;
  logic [WIDTH-1:0]     mul_in2;
  logic [2*WIDTH-1:0]   mul_res;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [15:0]          err_cnt;
  logic [15:0]          first_err_idx;
`ifdef MAS_MUL_BIST_ERR_INJECT_EN
  logic                 inj_err;

  modport master (
    output start, inj_err, mul_res,
    input  mul_in1, mul_in2, busy, done, pass, err_cnt, first_err_idx
  );
  modport slave (
    input  start, inj_err, mul_res,
    output mul_in1, mul_in2, busy, done, pass, err_cnt, first_err_idx
  );
`else
  modport master (
    output start, mul_res,
    input  mul_in1, mul_in2, busy, done, pass, err_cnt, first_err_idx
  );
  modport slave (
    input  start, mul_res,
    output mul_in1, mul_in2, busy, done, pass, err_cnt, first_err_idx
  );
`endif
endinterface

`default_nettype wire

// File: rtl/mas_mul_bist.sv
// ============================================================================
// mas_mul_bist : LFSR-driven self-test engine for the radix multiplier
// Rev 1.0 -- optional error injection under MAS_MUL_BIST_ERR_INJECT_EN
// ============================================================================
`default_nettype none

module mas_mul_bist #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned LAT     = 4,
  parameter int unsigned NUM_VEC = 256,
  parameter int unsigned SEED    = 16'hACE1,
  parameter int unsigned POLY    = 16'hB400
) (
  input  logic           clk,
  input  logic           rst,
  mas_mul_bist_if.slave  bus
);

  localparam int unsigned      c_half       = WIDTH / 2;
  localparam logic [WIDTH-1:0] c_seed_trunc = WIDTH'(SEED);
  localparam logic [WIDTH-1:0] c_seed       = (c_seed_trunc == '0) ? WIDTH'(1) : c_seed_trunc;
  localparam logic [WIDTH-1:0] c_poly       = WIDTH'(POLY);
  localparam logic [15:0]      c_last_vec   = 16'(NUM_VEC - 1);
  localparam logic [3:0]       c_last_drain = 4'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     lfsr_q;
  logic [WIDTH-1:0]     lfsr_d;
  logic [WIDTH-1:0]     rot_d;
  logic [15:0]          issue_cnt_q;
  logic [15:0]          chk_cnt_q;
  logic [3:0]           drain_cnt_q;
  logic [WIDTH-1:0]     in1_q;
  logic [WIDTH-1:0]     in2_q;
  logic                 drv_vld_q;
  logic [2*WIDTH-1:0]   prod_d;
  logic [2*WIDTH-1:0]   exp_q [LAT];
  logic [LAT-1:0]       vld_q;
  logic                 mismatch_d;
  logic [15:0]          err_cnt_q;
  logic [15:0]          err_cnt_d;
  logic [15:0]          first_err_q;
  logic [15:0]          first_err_d;
  logic                 busy_q;
  logic                 done_q;
  logic                 pass_q;
  logic                 leave_done_d;

  assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ c_poly) : (lfsr_q >> 1);
  assign rot_d  = (lfsr_q << c_half) | (lfsr_q >> (WIDTH - c_half));

`ifdef MAS_MUL_BIST_ERR_INJECT_EN
  logic inj_q;
  logic flip_q;
  // The flip travels with vector 0's operands so it lands on that product only.
  assign prod_d = ((2*WIDTH)'(in1_q) * (2*WIDTH)'(in2_q)) ^ (2*WIDTH)'(flip_q);
`else
  assign prod_d = (2*WIDTH)'(in1_q) * (2*WIDTH)'(in2_q);
`endif

  assign mismatch_d   = vld_q[LAT-1] && (exp_q[LAT-1] != bus.mul_res);
  assign leave_done_d = (state_q == S_DONE) && bus.start;

  // Final check and DONE entry share an edge, so pass must see this cycle's miss.
  always_comb begin
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    if (mismatch_d) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      if (first_err_q == 16'hFFFF) first_err_d = chk_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= c_seed;
      issue_cnt_q <= '0;
      chk_cnt_q   <= '0;
      drain_cnt_q <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      drv_vld_q   <= 1'b0;
      vld_q       <= '0;
      for (int i = 0; i < int'(LAT); i++) exp_q[i] <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
`ifdef MAS_MUL_BIST_ERR_INJECT_EN
      inj_q       <= 1'b0;
      flip_q      <= 1'b0;
`endif
    end else begin
      exp_q[0] <= prod_d;
      vld_q[0] <= drv_vld_q;
      for (int i = 1; i < int'(LAT); i++) begin
        exp_q[i] <= exp_q[i-1];
        vld_q[i] <= vld_q[i-1];
      end
      if (vld_q[LAT-1]) chk_cnt_q <= chk_cnt_q + 16'd1;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;

      in1_q     <= '0;
      in2_q     <= '0;
      drv_vld_q <= 1'b0;
`ifdef MAS_MUL_BIST_ERR_INJECT_EN
      flip_q    <= 1'b0;
`endif
      busy_q <= (state_q == S_RUN) || (state_q == S_DRAIN);
      done_q <= (state_q == S_DONE) && !leave_done_d;
      pass_q <= (state_q == S_DONE) && !leave_done_d && (err_cnt_d == 16'd0);

      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q     <= S_RUN;
            lfsr_q      <= c_seed;
            issue_cnt_q <= '0;
            chk_cnt_q   <= '0;
            err_cnt_q   <= '0;
            first_err_q <= 16'hFFFF;
`ifdef MAS_MUL_BIST_ERR_INJECT_EN
            inj_q       <= bus.inj_err;
`endif
          end
        end
        S_RUN: begin
          in1_q       <= lfsr_q;
          in2_q       <= rot_d;
          drv_vld_q   <= 1'b1;
          lfsr_q      <= lfsr_d;
          issue_cnt_q <= issue_cnt_q + 16'd1;
`ifdef MAS_MUL_BIST_ERR_INJECT_EN
          flip_q      <= inj_q && (issue_cnt_q == 16'd0);
`endif
          if (issue_cnt_q == c_last_vec) begin
            state_q     <= S_DRAIN;
            drain_cnt_q <= '0;
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q == c_last_drain) state_q <= S_DONE;
          else drain_cnt_q <= drain_cnt_q + 4'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mul_in1       = in1_q;
  assign bus.mul_in2       = in2_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_cnt       = err_cnt_q;
  assign bus.first_err_idx = first_err_q;

endmodule

`default_nettype wire

// File: doc/mas_mul_bist.md
# mas_mul_bist

Built-in self-test engine that drives the radix multiplier's operand inputs and checks its product output. It is the hardware counterpart of the simulation stimulus/check path. Pseudo-random operand pairs are issued one per clock. A latency-matched expected product is computed internally and compared against `mul_res`. Mismatches are counted and the first failing vector index is recorded. It sits beside `mas_mul_radix_top` in silicon test builds, with its `mul_in1`/`mul_in2` wired to the multiplier's `in1`/`in2` and the multiplier's `res` wired to `mul_res`.

## Interface
- `WIDTH`, 16: operand width; product is 2*WIDTH.
- `LAT`, 4: multiplier latency in cycles from operand drive to valid `res`; legal range 1..15.
- `NUM_VEC`, 256: vectors per run; legal range 1..65535.
- `SEED`, 16'hACE1: LFSR seed, truncated to WIDTH bits; a zero seed is replaced by 1.
- `POLY`, 16'hB400: Galois LFSR feedback mask, truncated to WIDTH bits.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: run request; a one-cycle pulse.
- `mul_in1`, output, WIDTH: operand A to the multiplier.
- `mul_in2`, output, WIDTH: operand B to the multiplier.
- `mul_res`, input, 2*WIDTH: product from the multiplier.
- `busy`, output, 1: high in RUN and DRAIN.
- `done`, output, 1: high in DONE.
- `pass`, output, 1: high in DONE when `err_cnt`==0.
- `err_cnt`, output, 16: mismatch count; saturates at 16'hFFFF.
- `first_err_idx`, output, 16: index of the first mismatching vector; 16'hFFFF if none.

## Operation
- The FSM has four states: IDLE, RUN, DRAIN, DONE.
- IDLE or DONE with `start`=1 → RUN. On that edge:
  - reload the LFSR with SEED;
  - clear the issue and check counters;
  - set `err_cnt`=0 and `first_err_idx`=16'hFFFF.
- RUN issues one vector per cycle. Vector k drives `mul_in1`=lfsr and `mul_in2`=lfsr rotated left by WIDTH/2.
- The LFSR then advances one Galois step: if lsb=1, lfsr=(lfsr>>1)^POLY; otherwise lfsr=lfsr>>1.
- RUN → DRAIN after vector NUM_VEC-1 is issued.
- DRAIN lasts exactly LAT cycles, then → DONE.
- DONE holds the results until the next `start`.
- Expected product is the full 2*WIDTH-bit unsigned product of the driven operands.
  - It is pushed into a LAT-deep shift register together with a valid bit.
  - When the valid bit emerges, it is compared with `mul_res` in the same cycle.
- On a mismatch:
  - `err_cnt` increments, saturating at 16'hFFFF;
  - `first_err_idx` is loaded with the check counter, only if it still equals 16'hFFFF.
- Outside RUN, `mul_in1` and `mul_in2` are 0 and no valid entries enter the delay line.
- `start` in RUN or DRAIN is ignored.
- Reset in any state returns all state to reset values, including the delay-line valid bits. A run interrupted by reset produces no result.

## Timing
- Reset values:
  - state IDLE, lfsr=SEED;
  - `mul_in1`=0, `mul_in2`=0;
  - `busy`=0, `done`=0, `pass`=0;
  - `err_cnt`=0, `first_err_idx`=0.
- All outputs are registered.
- With `start` sampled at edge E:
  - vector k is driven in cycle E+1+k;
  - it is checked in cycle E+1+k+LAT;
  - `done` rises at edge E+NUM_VEC+LAT+1.
- `busy` is high for exactly NUM_VEC+LAT cycles.
- Coincident mismatch on the final check cycle: the mismatch is counted before the DONE transition, so `pass` reflects it.
- `start` in DONE: `done` and `pass` drop on the next edge.

## Configuration
- Macro: `MAS_MUL_BIST_ERR_INJECT_EN`.
- Defined:
  - adds input `inj_err` (1 bit), sampled together with `start`;
  - if it is high, bit 0 of the expected product for vector 0 is inverted;
  - result: exactly one forced mismatch, `err_cnt`=1, `first_err_idx`=0 against a correct multiplier.
- Undefined: the port is absent and there is no injection logic.

## Test plan
- **Clean run.** Ideal multiplier model with LAT=4, NUM_VEC=16, start at edge 0.
  - vector 0 drives `mul_in1`=16'hACE1, `mul_in2`=16'hE1AC;
  - `done` rises at edge 21 with `pass`=1, `err_cnt`=0, `first_err_idx`=16'hFFFF;
  - `busy` is high for 20 cycles.
- **Stuck-at fault.** Model forces `res[3]`=1.
  - `pass`=0 and `err_cnt` equals the number of vectors whose true product has bit 3=0;
  - `first_err_idx` is the lowest such index.
- **Latency mismatch.** Model LAT=5 against BIST LAT=4 → `err_cnt`≥NUM_VEC-1 and `first_err_idx`=0.
- **Reset and restart.**
  - `rst` pulsed at cycle 8 of RUN → next cycle `busy`=0, `mul_in1`=0, `err_cnt`=0;
  - a new `start` reproduces the identical sequence, starting with 16'hACE1.
- **Ignored start.** `start` re-pulsed in RUN and in DRAIN → no restart; `done` still rises at edge 21.
- **Error injection.** With `MAS_MUL_BIST_ERR_INJECT_EN` defined, `inj_err`=1 and an ideal model → `err_cnt`=1, `first_err_idx`=0, `pass`=0.
